rect_filler: RTL and testbench
==============================

Name: rect_filler

Overview:
- Initiator side of the line-drawing command handshake. It fills a solid rectangle by issuing one vertical-line command per column to a downstream vertical-line responder.
- The responder behaves as follows:
  - It accepts a command on the rising edge of `start`.
  - It pulses `done` for one cycle on its last pixel.
  - It returns to idle only after `start` is seen low.
- rect_filler sits between the shape/command logic and the line responder. It owns column sequencing, x clipping and the start/done protocol.

Parameters:
- X_LIMIT, 320: first illegal x column. Columns at x >= X_LIMIT are never issued.
- TIMEOUT_CYCLES, 1023: watchdog limit in clk cycles per line. Used only with RECT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset. Sampled on posedge clk; 0 = reset.
- go  in  1  level request to fill a rectangle. Sampled in IDLE.
- x0  in  9  left column of the rectangle.
- y0  in  8  top row, passed to every line.
- width  in  9  number of columns. 0 means an empty rectangle.
- height  in  8  line height code, passed through unchanged. The responder draws height+1 pixels.
- line_done  in  1  one-cycle done pulse from the line responder.
- line_start  out  1  start request to the line responder.
- line_x  out  9  column of the current line.
- line_y  out  8  latched y0.
- line_height  out  8  latched height.
- busy  out  1  high in ISSUE or GAP.
- finished  out  1  high while in state FIN.
- timeout_err  out  1  present only when RECT_TIMEOUT_EN is defined.

Behaviour:
- Reset (reset==0 at posedge), regardless of state:
  - state=IDLE.
  - line_start, busy, finished and timeout_err = 0.
  - col=0.
  - Latched x/y/height/width = 0.
  - Reset mid-line drops line_start the next cycle. The responder is expected to reset alongside.
- States: IDLE, ISSUE, GAP, FIN. All outputs are registered or decoded from the registered state.
- IDLE:
  - If go=1, latch x0, y0, height and width, and set col=0.
  - If width==0 or x0>=X_LIMIT, go to FIN. No line is issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - line_start=1.
  - line_x = x_base + col, computed in 10 bits; only the lower 9 bits are driven.
  - Hold until line_done=1.
  - On line_done, compute last = (col == width_l-1) OR (x_base+col+1 >= X_LIMIT), with 10-bit compare.
  - If last, go to FIN. Otherwise col<=col+1 and go to GAP.
- GAP:
  - line_start=0 for exactly one cycle, so the responder leaves its finish state.
  - Then go to ISSUE.
  - Consequence: the next start rises 2 cycles after the line_done pulse.
- FIN:
  - finished=1.
  - Stay in FIN while go=1. Go to IDLE when go=0, as a level handshake.
  - line_start=0 throughout FIN.
- line_done outside ISSUE is ignored.
- go changing during ISSUE or GAP is ignored; the inputs stay latched.
- Column count: a completed rectangle with no clipping issues exactly width lines. With clipping it issues min(width, X_LIMIT-x0) lines.
- width=511 with x0=0 is legal: 9-bit col, no overflow, because col never exceeds width-1.

Optional Feature:
- Macro: RECT_TIMEOUT_EN.
- Defined:
  - A 10-bit-min watchdog counter is cleared on entry to ISSUE and increments each ISSUE cycle.
  - If it reaches TIMEOUT_CYCLES without line_done, the block drops line_start and goes to FIN.
  - It also sets timeout_err=1, which stays sticky until the next go accepted in IDLE or until reset.
- Undefined:
  - No counter and no timeout_err port.
  - ISSUE waits indefinitely.

Decomposition:
- Package rect_pkg holds:
  - The state enum typedef (2-bit: IDLE, ISSUE, GAP, FIN).
  - The coordinate width constants X_W=9 and Y_W=8.
- One natural sub-module: rect_col_counter, holding col plus the last-column/clip compare.
- The FSM stays in rect_filler.

Test Plan:
1. x0=10, y0=20, width=3, height=4, with a responder model pulsing done 5 cycles after start.
   - Expect 3 starts with line_x = 10, 11, 12 and line_y=20.
   - Expect start low exactly 1 cycle between lines, then finished=1 until go drops.
2. width=0, go=1.
   - Expect FIN next cycle and finished=1.
   - line_start is never asserted.
3. x0=318, width=5, X_LIMIT=320.
   - Expect lines at x=318 and 319 only, then FIN.
   - Also x0=320: FIN directly, zero lines.
4. Reset mid-operation: reset=0 during the second ISSUE of a width=4 fill.
   - Next cycle: line_start=0, busy=0, state IDLE.
   - After release with go=1, the fill restarts at col 0.
5. Spurious line_done in GAP and in IDLE.
   - Ignored; the column sequence is unchanged.
   - go held high through FIN keeps finished=1 with no re-trigger.
6. With RECT_TIMEOUT_EN and TIMEOUT_CYCLES=16, the responder never pulses done.
   - line_start drops after 16 ISSUE cycles, timeout_err=1 and finished=1.
   - timeout_err clears on the next accepted go.

Source files
------------

// File: rtl/rect_pkg.sv
// Shared state encoding and coordinate widths for the rectangle filler.
package rect_pkg;

  localparam int unsigned X_W = 9;
  localparam int unsigned Y_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/rect_col_counter.sv
// Column index for the current fill, plus the last-column / right-edge clip test.
module rect_col_counter
  import rect_pkg::*;
#(
  parameter int unsigned X_LIMIT = 320
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           inc,
  input  logic [X_W-1:0] x_base,
  input  logic [X_W-1:0] width_l,
  output logic [X_W-1:0] line_x,
  output logic           last
);

  localparam logic [X_W:0]   XLIM   = (X_W + 1)'(X_LIMIT);
  localparam logic [X_W-1:0] ONE    = X_W'(1);
  localparam logic [X_W:0]   ONE_WD = (X_W + 1)'(1);

  logic [X_W-1:0] col;
  logic [X_W:0]   x_abs;

  always_ff @(posedge clk) begin
    if (!reset) begin
      col <= '0;
    end else if (clear) begin
      col <= '0;
    end else if (inc) begin
      col <= col + ONE;
    end
  end

  // Sum kept at 10 bits so the clip compare cannot wrap near x=511.
  always_comb begin
    x_abs  = {1'b0, x_base} + {1'b0, col};
    line_x = x_abs[X_W-1:0];
    last   = (col == (width_l - ONE)) || ((x_abs + ONE_WD) >= XLIM);
  end

endmodule

// File: rtl/rect_filler.sv
// Fills a rectangle by issuing one vertical-line command per column.
// Optional line watchdog and timeout_err port enabled by RECT_TIMEOUT_EN.
module rect_filler
  import rect_pkg::*;
#(
  parameter int unsigned X_LIMIT        = 320,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           go,
  input  logic [X_W-1:0] x0,
  input  logic [Y_W-1:0] y0,
  input  logic [X_W-1:0] width,
  input  logic [Y_W-1:0] height,
  input  logic           line_done,
  output logic           line_start,
  output logic [X_W-1:0] line_x,
  output logic [Y_W-1:0] line_y,
  output logic [Y_W-1:0] line_height,
  output logic           busy,
  output logic           finished
`ifdef RECT_TIMEOUT_EN
  ,
  output logic           timeout_err
`endif
);

  localparam logic [X_W:0] XLIM = (X_W + 1)'(X_LIMIT);

  if (X_LIMIT < 1 || X_LIMIT > 512) begin : g_bad_xlimit
    $error("X_LIMIT must be in 1..512");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t         state_q, state_d;
  logic [X_W-1:0] x_base, width_l;
  logic           accept, empty, last, col_inc, wd_expired;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_base      <= '0;
      width_l     <= '0;
      line_y      <= '0;
      line_height <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x_base      <= x0;
        width_l     <= width;
        line_y      <= y0;
        line_height <= height;
      end
    end
  end

  always_comb begin
    accept  = (state_q == IDLE) && go;
    empty   = (width == '0) || ({1'b0, x0} >= XLIM);
    col_inc = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (go) state_d = empty ? FIN : ISSUE;
      ISSUE: begin
        if (line_done) begin
          if (last) begin
            state_d = FIN;
          end else begin
            state_d = GAP;
            col_inc = 1'b1;
          end
        end else if (wd_expired) begin
          state_d = FIN;
        end
      end
      GAP:     state_d = ISSUE;
      FIN:     if (!go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_start = (state_q == ISSUE);
    busy       = (state_q == ISSUE) || (state_q == GAP);
    finished   = (state_q == FIN);
  end

  rect_col_counter #(
    .X_LIMIT(X_LIMIT)
  ) u_col (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .inc    (col_inc),
    .x_base (x_base),
    .width_l(width_l),
    .line_x (line_x),
    .last   (last)
  );

`ifdef RECT_TIMEOUT_EN
  localparam int unsigned WD_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] wd;

  // Held at zero outside ISSUE, so every line starts with a fresh count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state_q != ISSUE) wd <= '0;
      else                  wd <= wd + WD_ONE;
      if (accept) begin
        timeout_err <= 1'b0;
      end else if ((state_q == ISSUE) && !line_done && wd_expired) begin
        timeout_err <= 1'b1;
      end
    end
  end

  assign wd_expired = (wd == WD_LAST);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_rect_filler.sv
// Randomised self-checking bench for rect_filler with a line-responder model.
`timescale 1ns/1ps
module tb_rect_filler;

  localparam int XL = 320;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       go = 1'b0;
  logic [8:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic [8:0] width = '0;
  logic [7:0] height = '0;
  logic       line_done;
  logic       line_start;
  logic [8:0] line_x;
  logic [7:0] line_y;
  logic [7:0] line_height;
  logic       busy;
  logic       finished;
`ifdef RECT_TIMEOUT_EN
  logic       timeout_err;
`endif

  logic resp_done = 1'b0;
  logic spur_done = 1'b0;
  assign line_done = resp_done | spur_done;

  int n_checks = 0;
  int n_errors = 0;

  rect_filler #(
    .X_LIMIT(XL),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .x0         (x0),
    .y0         (y0),
    .width      (width),
    .height     (height),
    .line_done  (line_done),
    .line_start (line_start),
    .line_x     (line_x),
    .line_y     (line_y),
    .line_height(line_height),
    .busy       (busy),
    .finished   (finished)
`ifdef RECT_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Responder: takes a command on a rising start, pulses done resp_delay
  // cycles later, then waits for start to fall.
  int resp_delay = 5;
  bit resp_en = 1'b1;
  bit spur_gap = 1'b0;
  int r_cnt = 0;
  bit r_act = 1'b0;
  bit r_wait_low = 1'b0;

  always @(negedge clk) begin
    resp_done = 1'b0;
    if (!reset) begin
      r_act = 1'b0;
      r_wait_low = 1'b0;
    end else if (r_wait_low) begin
      if (!line_start) r_wait_low = 1'b0;
    end else if (r_act) begin
      r_cnt--;
      if (r_cnt == 0) begin
        resp_done = resp_en;
        r_act = 1'b0;
        r_wait_low = 1'b1;
      end
    end else if (line_start) begin
      r_act = 1'b1;
      r_cnt = resp_delay;
    end
    if (spur_gap && busy && !line_start) resp_done = 1'b1;
  end

  // Monitor: records each issued line and checks inter-line spacing.
  typedef struct {
    int x;
    int y;
    int h;
  } line_t;
  line_t obs[$];
  int tnow = 0;
  int last_t = -1;
  int gap_run = 0;
  int bad_gaps = 0;
  bit prev_start = 1'b0;

  always @(negedge clk) begin
    tnow++;
    if (!reset) begin
      prev_start = 1'b0;
      gap_run = 0;
      last_t = -1;
    end else begin
      if (busy && !line_start) gap_run++;
      if (line_start && !prev_start) begin
        if (last_t >= 0 && ((tnow - last_t) != resp_delay + 2 || gap_run != 1)) bad_gaps++;
        obs.push_back('{int'(line_x), int'(line_y), int'(line_height)});
        last_t = tnow;
        gap_run = 0;
      end
      prev_start = line_start;
    end
  end

  function automatic int model_lines(input int xs, input int w);
    if (xs >= XL) return 0;
    return (w < XL - xs) ? w : XL - xs;
  endfunction

  task automatic do_fill(input int xv, input int yv, input int wv, input int hv,
                         input int dly, input int hold);
    int n;
    int cyc;
    int cnt;
    n = model_lines(xv, wv);
    @(negedge clk);
    x0 = 9'(xv); y0 = 8'(yv); width = 9'(wv); height = 8'(hv);
    resp_delay = dly;
    obs.delete();
    bad_gaps = 0;
    last_t = -1;
    go = 1'b1;
    @(negedge clk);
    n_checks++;
    if (n == 0 && finished !== 1'b1) begin
      n_errors++;
      $display("FAIL empty_fin_latency x0=%0d w=%0d finished=%b expected 1", xv, wv, finished);
    end else if (n != 0 && line_start !== 1'b1) begin
      n_errors++;
      $display("FAIL first_start_latency x0=%0d w=%0d line_start=%b expected 1", xv, wv, line_start);
    end
    // Inputs wander while the fill runs; only latched values may be used.
    x0 = 9'($urandom); y0 = 8'($urandom); width = 9'($urandom); height = 8'($urandom);
    cyc = 0;
    while (!finished && cyc < 10000) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (finished !== 1'b1) begin
      n_errors++;
      $display("FAIL fill_complete x0=%0d w=%0d finished=%b expected 1", xv, wv, finished);
    end
    n_checks++;
    if (obs.size() != n) begin
      n_errors++;
      $display("FAIL line_count x0=%0d w=%0d got %0d expected %0d", xv, wv, obs.size(), n);
    end
    foreach (obs[i]) begin
      if (i < n) begin
        n_checks++;
        if (obs[i].x != xv + i || obs[i].y != yv || obs[i].h != hv) begin
          n_errors++;
          $display("FAIL line_fields idx=%0d got x=%0d y=%0d h=%0d expected x=%0d y=%0d h=%0d",
                   i, obs[i].x, obs[i].y, obs[i].h, xv + i, yv, hv);
        end
      end
    end
    n_checks++;
    if (bad_gaps != 0) begin
      n_errors++;
      $display("FAIL line_spacing bad gaps=%0d expected 0", bad_gaps);
    end
    if (hold > 0) begin
      cnt = obs.size();
      repeat (hold) @(negedge clk);
      n_checks++;
      if (finished !== 1'b1 || line_start !== 1'b0 || busy !== 1'b0 || obs.size() != cnt) begin
        n_errors++;
        $display("FAIL fin_hold finished=%b start=%b busy=%b lines=%0d expected 1 0 0 %0d",
                 finished, line_start, busy, obs.size(), cnt);
      end
    end
    go = 1'b0;
    @(negedge clk);
    n_checks++;
    if (finished !== 1'b0 || busy !== 1'b0 || line_start !== 1'b0) begin
      n_errors++;
      $display("FAIL back_to_idle finished=%b busy=%b start=%b expected 0 0 0",
               finished, busy, line_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    go = 1'b1;
    x0 = 9'd77; width = 9'd5;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({line_start, busy, finished, line_x, line_y, line_height} !== '0) begin
      n_errors++;
      $display("FAIL reset_state start=%b busy=%b fin=%b x=%0d y=%0d h=%0d expected all 0",
               line_start, busy, finished, line_x, line_y, line_height);
    end
`ifdef RECT_TIMEOUT_EN
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_timeout_err got %b expected 0", timeout_err);
    end
`endif
    go = 1'b0;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    do_fill(10, 20, 3, 4, 5, 3);
    do_fill(50, 9, 0, 1, 5, 2);
    do_fill(318, 33, 5, 7, 3, 0);
    do_fill(320, 33, 5, 7, 3, 0);
    do_fill(0, 255, 511, 255, 1, 0);
  endtask

  task automatic test_random();
    int xv;
    int wv;
    for (int k = 0; k < 14; k++) begin
      case ($urandom_range(0, 2))
        0: xv = $urandom_range(0, 511);
        1: xv = $urandom_range(295, 325);
        default: xv = $urandom_range(0, 100);
      endcase
      wv = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 30);
      do_fill(xv, $urandom_range(0, 255), wv, $urandom_range(0, 255),
              $urandom_range(1, 6), $urandom_range(0, 2));
    end
  endtask

  task automatic test_reset_mid();
    int c;
    @(negedge clk);
    x0 = 9'd100; y0 = 8'd40; width = 9'd4; height = 8'd12;
    resp_delay = 4;
    obs.delete();
    go = 1'b1;
    c = 0;
    while (obs.size() < 2 && c < 200) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (obs.size() < 2 || line_start !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_mid_setup lines=%0d start=%b expected 2 1", obs.size(), line_start);
    end
    reset = 1'b0;
    go = 1'b0;
    @(negedge clk);
    n_checks++;
    if (line_start !== 1'b0 || busy !== 1'b0 || finished !== 1'b0 || line_x !== 9'd0) begin
      n_errors++;
      $display("FAIL reset_mid start=%b busy=%b fin=%b x=%0d expected 0 0 0 0",
               line_start, busy, finished, line_x);
    end
    reset = 1'b1;
    do_fill(100, 40, 4, 12, 4, 0);
  endtask

  task automatic test_spurious();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || line_start !== 1'b0 || finished !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_spurious busy=%b start=%b fin=%b expected 0 0 0",
               busy, line_start, finished);
    end
    spur_gap = 1'b1;
    do_fill(200, 17, 6, 3, 3, 4);
    spur_gap = 1'b0;
  endtask

`ifdef RECT_TIMEOUT_EN
  task automatic test_timeout();
    int hi;
    int c;
    @(negedge clk);
    resp_en = 1'b0;
    resp_delay = 3;
    obs.delete();
    x0 = 9'd5; y0 = 8'd6; width = 9'd3; height = 8'd2;
    go = 1'b1;
    hi = 0;
    c = 0;
    @(negedge clk);
    while (!finished && c < 200) begin
      if (line_start) hi++;
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (hi != TO || finished !== 1'b1 || timeout_err !== 1'b1 || obs.size() != 1) begin
      n_errors++;
      $display("FAIL timeout issue_cycles=%0d fin=%b err=%b lines=%0d expected %0d 1 1 1",
               hi, finished, timeout_err, obs.size(), TO);
    end
    go = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    n_checks++;
    if (timeout_err !== 1'b1 || finished !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_sticky err=%b fin=%b expected 1 0", timeout_err, finished);
    end
    do_fill(30, 1, 2, 1, 2, 0);
    n_checks++;
    if (timeout_err !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_clear err=%b expected 0", timeout_err);
    end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL global_watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    test_spurious();
`ifdef RECT_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
